// File: rtl/uart_tx_param.sv
//------------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised UART serial transmitter. Accepts one word per valid/ready
// handshake and shifts it out LSB first as START, DBITS data bits, an
// optional parity bit and STOP_BITS stop bits. Each bit lasts OVERSAMPLE
// pulses of the shared baud generator's sample_tick.
//
// Parameters
//   DBITS        data bits per frame (5..9)
//   OVERSAMPLE   sample_ticks per bit period (4..64)
//   STOP_BITS    stop bits (1 or 2)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//
// Optional feature macro
//   UART_TX_PARITY_EN  when defined, PARITY_MODE is honoured and the PARITY
//                      state is reachable. When undefined, no parity logic is
//                      built and DATA always proceeds straight to STOP.
//
// Ports
//   clk_100MHz   in   system clock, rising edge
//   reset        in   asynchronous active-high reset
//   sample_tick  in   one-cycle baud pulse
//   tx_valid     in   source offers tx_data
//   tx_data      in   word to send, captured on acceptance only
//   tx_ready     out  high while idle (word can be accepted)
//   tx_done      out  one-cycle pulse when the last stop tick completes
//   busy         out  high in every state except IDLE
//   tx           out  registered serial line, idles high
//   state_out    out  IDLE=0 START=1 DATA=2 PARITY=3 STOP=4
//------------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DBITS       = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             tx_valid,
  input  logic [DBITS-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_done,
  output logic             busy,
  output logic             tx,
  output logic [2:0]       state_out
);

  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DBITS > 1) ? $clog2(DBITS) : 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != 0);

  // Even parity makes the total count of ones even; odd makes it odd.
  function automatic logic parity_bit(input logic [DBITS-1:0] d);
    return (PARITY_MODE == 2) ? ~^d : ^d;
  endfunction
`else
  // Parity is compiled out; PARITY_MODE is only referenced so the parameter
  // list stays identical between builds.
  localparam bit PAR_ON = 1'b0 & (PARITY_MODE != 0);
`endif

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      tick_q,  tick_d;
  logic [BW-1:0]      bit_q,   bit_d;
  logic               stop_q,  stop_d;
  logic [DBITS-1:0]   shift_q, shift_d;
  logic               tx_q,    tx_d;
  logic               done_q,  done_d;
`ifdef UART_TX_PARITY_EN
  logic               par_q,   par_d;
`endif

  logic bit_end;

  // A bit period closes on the OVERSAMPLE-th tick since it began.
  assign bit_end = sample_tick && (tick_q == TICK_LAST);

  // State register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    // Ticks only matter while a frame is in flight.
    if (state_q != IDLE && sample_tick) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d = START;
          shift_d = tx_data;
          tick_d  = '0;
          bit_d   = '0;
          stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
          par_d   = parity_bit(tx_data);
`endif
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = PAR_ON ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The line level is decoded from the state being entered so that tx
    // changes on the same edge as the FSM and comes straight from a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign tx        = tx_q;
  assign tx_done   = done_q;
  assign tx_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign state_out = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
module tb_uart_tx_param;

  localparam int OS = 16;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       valid   [3];
  logic [8:0] data    [3];
  logic       tx_w    [3];
  logic       done_w  [3];
  logic       ready_w [3];
  logic       busy_w  [3];
  logic [2:0] state_w [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  // dut0: 8 bits, 1 stop, even; dut1: 7 bits, 2 stop, odd; dut2: 8 bits, 1 stop, odd
  uart_tx_param #(.DBITS(8), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_MODE(1)) dut0 (
    .clk_100MHz(clk_100MHz), .reset(reset), .sample_tick(sample_tick),
    .tx_valid(valid[0]), .tx_data(data[0][7:0]), .tx_ready(ready_w[0]),
    .tx_done(done_w[0]), .busy(busy_w[0]), .tx(tx_w[0]), .state_out(state_w[0]));

  uart_tx_param #(.DBITS(7), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_MODE(2)) dut1 (
    .clk_100MHz(clk_100MHz), .reset(reset), .sample_tick(sample_tick),
    .tx_valid(valid[1]), .tx_data(data[1][6:0]), .tx_ready(ready_w[1]),
    .tx_done(done_w[1]), .busy(busy_w[1]), .tx(tx_w[1]), .state_out(state_w[1]));

  uart_tx_param #(.DBITS(8), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_MODE(2)) dut2 (
    .clk_100MHz(clk_100MHz), .reset(reset), .sample_tick(sample_tick),
    .tx_valid(valid[2]), .tx_data(data[2][7:0]), .tx_ready(ready_w[2]),
    .tx_done(done_w[2]), .busy(busy_w[2]), .tx(tx_w[2]), .state_out(state_w[2]));

  // Free-running tick, one every 4 clocks, changed on the falling edge.
  initial begin
    int ph;
    ph = 0;
    sample_tick = 1'b0;
    forever begin
      @(negedge clk_100MHz);
      ph = (ph + 1) % 4;
      sample_tick = (ph == 0);
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dbits_of(input int idx);
    return (idx == 1) ? 7 : 8;
  endfunction

  function automatic int stops_of(input int idx);
    return (idx == 1) ? 2 : 1;
  endfunction

  function automatic int pmode_of(input int idx);
    return (idx == 0) ? 1 : 2;
  endfunction

  // Reference frame: list of line levels, one per bit period.
  task automatic model_frame(input int idx, input logic [8:0] w,
                             output logic [11:0] bits, output int len);
    logic q[$];
    int   ones;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < dbits_of(idx); i++) begin
      q.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (PAR_EN && pmode_of(idx) != 0) begin
      if (pmode_of(idx) == 1) q.push_back((ones % 2) == 1);
      else                    q.push_back((ones % 2) == 0);
    end
    for (int s = 0; s < stops_of(idx); s++) q.push_back(1'b1);
    bits = '0;
    for (int i = 0; i < q.size(); i++) bits[i] = q[i];
    len = q.size();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Offer a word and return #1 after the accepting edge.
  task automatic accept(input int idx, input logic [8:0] word, input bit hold);
    int cyc;
    bit ok;
    cyc = 0;
    ok  = 1'b0;
    @(negedge clk_100MHz);
    valid[idx] = 1'b1;
    data[idx]  = word;
    while (!ok && cyc < 2000) begin
      if (ready_w[idx]) ok = 1'b1;
      else begin
        @(negedge clk_100MHz);
        cyc++;
      end
    end
    check("accept_ready", 32'(ok), 32'd1);
    @(posedge clk_100MHz);
    #1;
    if (!hold) valid[idx] = 1'b0;
    data[idx] = ~word;
  endtask

  // Called #1 after acceptance; samples each bit mid-period and times tx_done.
  task automatic capture(input int idx, input logic [11:0] exp_bits,
                         input int exp_len, input string name);
    int          ticks, cyc, total, done_at;
    bit          t, done_on_tick, ready_bad;
    logic [11:0] got;
    ticks = 0; cyc = 0; total = exp_len * OS; done_at = -1;
    done_on_tick = 1'b0; ready_bad = 1'b0; got = '0;
    check({name, "_start_tx"}, 32'(tx_w[idx]), 32'd0);
    check({name, "_start_state"}, 32'(state_w[idx]), 32'd1);
    while (done_at < 0 && cyc < total * 4 + 64) begin
      @(posedge clk_100MHz);
      t = sample_tick;
      if (t) ticks++;
      #1;
      cyc++;
      if (t && (ticks % OS) == OS / 2 && (ticks / OS) < 12) got[ticks / OS] = tx_w[idx];
      if (done_w[idx]) begin
        done_at = ticks;
        done_on_tick = t;
      end else if (ready_w[idx]) begin
        ready_bad = 1'b1;
      end
    end
    check({name, "_bits"}, 32'(got), 32'(exp_bits));
    check({name, "_done_tick"}, 32'(done_at), 32'(total));
    check({name, "_done_on_tick"}, 32'(done_on_tick), 32'd1);
    check({name, "_ready_low"}, 32'(ready_bad), 32'd0);
    check({name, "_idle_tx"}, 32'(tx_w[idx]), 32'd1);
  endtask

  typedef struct {
    int          idx;
    logic [8:0]  word;
    logic [11:0] bits;
    int          len;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] mbits;
  int          mlen, ticks, cyc, done_cnt, dly, ridx;
  bit          bad;
  logic [8:0]  rword;

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end

`ifdef UART_TX_PARITY_EN
    vecs.push_back('{0, 9'h0A5, 12'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, "8E1_A5"});
    vecs.push_back('{2, 9'h0A5, 12'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, "8O1_A5"});
    vecs.push_back('{1, 9'h041, 12'({2'b11, 1'b1, 7'h41, 1'b0}), 11, "7O2_41"});
    vecs.push_back('{0, 9'h03C, 12'({1'b1, 1'b0, 8'h3C, 1'b0}), 11, "8E1_3C"});
    vecs.push_back('{0, 9'h001, 12'({1'b1, 1'b1, 8'h01, 1'b0}), 11, "8E1_01"});
    vecs.push_back('{2, 9'h000, 12'({1'b1, 1'b1, 8'h00, 1'b0}), 11, "8O1_00"});
    vecs.push_back('{1, 9'h07F, 12'({2'b11, 1'b0, 7'h7F, 1'b0}), 11, "7O2_7F"});
`else
    vecs.push_back('{0, 9'h0A5, 12'({1'b1, 8'hA5, 1'b0}), 10, "8N1_A5"});
    vecs.push_back('{2, 9'h0A5, 12'({1'b1, 8'hA5, 1'b0}), 10, "8N1b_A5"});
    vecs.push_back('{1, 9'h041, 12'({2'b11, 7'h41, 1'b0}), 10, "7N2_41"});
    vecs.push_back('{0, 9'h03C, 12'({1'b1, 8'h3C, 1'b0}), 10, "8N1_3C"});
    vecs.push_back('{0, 9'h001, 12'({1'b1, 8'h01, 1'b0}), 10, "8N1_01"});
    vecs.push_back('{2, 9'h000, 12'({1'b1, 8'h00, 1'b0}), 10, "8N1b_00"});
    vecs.push_back('{1, 9'h07F, 12'({2'b11, 7'h7F, 1'b0}), 10, "7N2_7F"});
`endif

    // Reset values, during and after reset
    repeat (3) @(negedge clk_100MHz);
    for (int i = 0; i < 3; i++) begin
      check("rst_tx", 32'(tx_w[i]), 32'd1);
      check("rst_done", 32'(done_w[i]), 32'd0);
      check("rst_busy", 32'(busy_w[i]), 32'd0);
      check("rst_ready", 32'(ready_w[i]), 32'd1);
      check("rst_state", 32'(state_w[i]), 32'd0);
    end
    reset = 1'b0;

    // Ticks and data changes while idle must not start anything
    bad = 1'b0;
    repeat (64) begin
      @(negedge clk_100MHz);
      for (int i = 0; i < 3; i++) data[i] = 9'($urandom);
      @(posedge clk_100MHz);
      #1;
      for (int i = 0; i < 3; i++)
        if (state_w[i] != 3'd0 || tx_w[i] != 1'b1 || busy_w[i] || done_w[i]) bad = 1'b1;
    end
    check("idle_ticks_ignored", 32'(bad), 32'd0);

    // Directed frame table
    for (int v = 0; v < vecs.size(); v++) begin
      accept(vecs[v].idx, vecs[v].word, 1'b0);
      capture(vecs[v].idx, vecs[v].bits, vecs[v].len, vecs[v].name);
    end

    // Back-to-back with tx_valid held high
    accept(0, 9'h055, 1'b1);
    data[0] = 9'h0AA;
    model_frame(0, 9'h055, mbits, mlen);
    capture(0, mbits, mlen, "b2b_55");
    @(posedge clk_100MHz);
    #1;
    check("b2b_second_start", 32'(state_w[0]), 32'd1);
    check("b2b_done_one_cycle", 32'(done_w[0]), 32'd0);
    valid[0] = 1'b0;
    model_frame(0, 9'h0AA, mbits, mlen);
    capture(0, mbits, mlen, "b2b_AA");

    // Reset during data bit 3 (bit 3 of 0xF7 is 0)
    accept(0, 9'h0F7, 1'b0);
    ticks = 0; cyc = 0;
    while (ticks < 4 * OS + 5 && cyc < 2000) begin
      @(posedge clk_100MHz);
      if (sample_tick) ticks++;
      #1;
      cyc++;
    end
    check("midrst_pre_tx", 32'(tx_w[0]), 32'd0);
    check("midrst_pre_state", 32'(state_w[0]), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_async_tx", 32'(tx_w[0]), 32'd1);
    check("midrst_async_state", 32'(state_w[0]), 32'd0);
    check("midrst_async_busy", 32'(busy_w[0]), 32'd0);
    done_cnt = 0;
    repeat (3) begin
      @(negedge clk_100MHz);
      if (done_w[0]) done_cnt++;
    end
    reset = 1'b0;
    bad = 1'b0;
    repeat (200) begin
      @(posedge clk_100MHz);
      #1;
      if (done_w[0]) done_cnt++;
      if (tx_w[0] != 1'b1 || state_w[0] != 3'd0) bad = 1'b1;
    end
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_line_idle", 32'(bad), 32'd0);
    model_frame(0, 9'h03C, mbits, mlen);
    accept(0, 9'h03C, 1'b0);
    capture(0, mbits, mlen, "midrst_3C");

    // Randomized words on random instances at random tick phases
    for (int r = 0; r < 9; r++) begin
      ridx  = int'($urandom_range(0, 2));
      rword = 9'($urandom) & ((9'd1 << dbits_of(ridx)) - 9'd1);
      dly   = int'($urandom_range(0, 5));
      repeat (dly) @(posedge clk_100MHz);
      model_frame(ridx, rword, mbits, mlen);
      accept(ridx, rword, 1'b0);
      capture(ridx, mbits, mlen, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
